id_stage_pipe: RTL

//  Decode stage with its own ID/EX pipeline register, valid/ready handshakes on both sides and load-use hazard bubbling.

---
 rtl/id_stage_pipe.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with GPR bank, branch/jump target resolution, ID/EX register,
// load-use bubbling, halt detection and a saturating stall counter. Optional macro: ID_WB_BYPASS_EN.
module id_stage_pipe #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int PC_SIZE             = 32,
  parameter int BUS_SIZE            = 32,
  parameter int STALL_CNT_SIZE      = 16
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_valid,
  output logic                                     o_ready,
  input  logic [BUS_SIZE-1:0]                      i_instruction,
  input  logic [PC_SIZE-1:0]                       i_next_seq_pc,
  input  logic                                     i_reg_write_enable,
  input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0]   i_reg_addr_wr,
  input  logic [BUS_SIZE-1:0]                      i_reg_bus_wr,
  output logic                                     o_next_pc_src,
  output logic [PC_SIZE-1:0]                       o_next_not_seq_pc,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic                                     o_reg_write,
  output logic                                     o_mem_write,
  output logic [1:0]                               o_reg_dst,
  output logic [1:0]                               o_mem_to_reg,
  output logic [1:0]                               o_alu_src,
  output logic [2:0]                               o_alu_op,
  output logic [BUS_SIZE-1:0]                      o_bus_a,
  output logic [BUS_SIZE-1:0]                      o_bus_b,
  output logic [BUS_SIZE-1:0]                      o_imm_ext_signed,
  output logic [4:0]                               o_rs,
  output logic [4:0]                               o_rt,
  output logic [4:0]                               o_rd,
  output logic [5:0]                               o_funct,
  output logic                                     o_halted,
  output logic [STALL_CNT_SIZE-1:0]                o_stall_count,
  output logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0]  o_bus_debug
);

  localparam int ADDR_W = $clog2(REGISTERS_BANK_SIZE);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t                    r_state;
  logic [BUS_SIZE-1:0]       r_bank [REGISTERS_BANK_SIZE];
  logic                      r_valid;
  logic                      r_reg_write;
  logic                      r_mem_write;
  logic [1:0]                r_reg_dst;
  logic [1:0]                r_mem_to_reg;
  logic [1:0]                r_alu_src;
  logic [2:0]                r_alu_op;
  logic [BUS_SIZE-1:0]       r_bus_a;
  logic [BUS_SIZE-1:0]       r_bus_b;
  logic [BUS_SIZE-1:0]       r_imm;
  logic [4:0]                r_rs;
  logic [4:0]                r_rt;
  logic [4:0]                r_rd;
  logic [5:0]                r_funct;
  logic [STALL_CNT_SIZE-1:0] r_stall;

  logic [5:0]          w_op;
  logic [4:0]          w_rs;
  logic [4:0]          w_rt;
  logic [4:0]          w_rd;
  logic [5:0]          w_funct;
  logic [15:0]         w_imm;
  logic [25:0]         w_dir;
  logic [BUS_SIZE-1:0] w_bus_a;
  logic [BUS_SIZE-1:0] w_bus_b;
  logic [BUS_SIZE-1:0] w_imm_ext;
  logic [PC_SIZE-1:0]  w_branch_off;
  logic                w_zero;
  logic [10:0]         w_ctrl;
  logic                w_pc_src;
  logic [1:0]          w_jmp_ctrl;
  logic                w_halt;
  logic                w_free;
  logic                w_load_use;
  logic                w_accept;
  logic                w_unused;

  assign w_op         = i_instruction[31:26];
  assign w_rs         = i_instruction[25:21];
  assign w_rt         = i_instruction[20:16];
  assign w_rd         = i_instruction[15:11];
  assign w_funct      = i_instruction[5:0];
  assign w_imm        = i_instruction[15:0];
  assign w_dir        = i_instruction[25:0];
  assign w_imm_ext    = {{(BUS_SIZE-16){w_imm[15]}}, w_imm};
  assign w_branch_off = {{(PC_SIZE-18){w_imm[15]}}, w_imm, 2'b00};
  assign w_unused     = ^i_instruction[10:6];

  // r0 stays zero because its writes are dropped; the bypass never forwards to r0 either
  always_comb begin
    w_bus_a = r_bank[w_rs[ADDR_W-1:0]];
    w_bus_b = r_bank[w_rt[ADDR_W-1:0]];
`ifdef ID_WB_BYPASS_EN
    if (i_reg_write_enable && (i_reg_addr_wr != '0) && (i_reg_addr_wr == w_rs[ADDR_W-1:0]))
      w_bus_a = i_reg_bus_wr;
    if (i_reg_write_enable && (i_reg_addr_wr != '0) && (i_reg_addr_wr == w_rt[ADDR_W-1:0]))
      w_bus_b = i_reg_bus_wr;
`endif
  end

  assign w_zero = (w_bus_a == w_bus_b);

  // Control word: [0] reg_write, [2:1] reg_dst, [4:3] mem_to_reg, [5] mem_write, [7:6] alu_src, [10:8] alu_op
  always_comb begin
    w_ctrl     = '0;
    w_pc_src   = 1'b0;
    w_jmp_ctrl = 2'd2;
    w_halt     = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        if (w_funct == FUNCT_JR) begin
          w_pc_src   = 1'b1;
          w_jmp_ctrl = 2'd1;
        end else begin
          w_ctrl = {3'b010, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1};
        end
      end
      OP_ADDI: w_ctrl = {3'b000, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1};
      OP_ORI:  w_ctrl = {3'b011, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1};
      OP_LW:   w_ctrl = {3'b000, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1};
      OP_SW:   w_ctrl = {3'b000, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0};
      OP_BEQ: begin
        w_ctrl   = {3'b001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
        w_pc_src = w_zero;
      end
      OP_BNE: begin
        w_ctrl   = {3'b001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
        w_pc_src = !w_zero;
      end
      OP_J: begin
        w_pc_src   = 1'b1;
        w_jmp_ctrl = 2'd0;
      end
      OP_HALT: w_halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (w_jmp_ctrl)
      2'd0:    o_next_not_seq_pc = {i_next_seq_pc[PC_SIZE-1:28], w_dir, 2'b00};
      2'd1:    o_next_not_seq_pc = w_bus_a[PC_SIZE-1:0];
      default: o_next_not_seq_pc = i_next_seq_pc + w_branch_off;
    endcase
  end

  assign w_free     = !r_valid || i_ready;
  assign w_load_use = r_valid && (r_mem_to_reg == 2'b01) && (r_rt != 5'd0) &&
                      ((r_rt == w_rs) || (r_rt == w_rt));
  assign o_ready    = (r_state == ST_RUN) && w_free && !w_load_use;
  assign w_accept   = i_valid && o_ready;
  assign o_next_pc_src = w_pc_src && w_accept;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < REGISTERS_BANK_SIZE; i++) r_bank[i] <= '0;
    end else if (i_reg_write_enable && (i_reg_addr_wr != '0)) begin
      r_bank[i_reg_addr_wr] <= i_reg_bus_wr;
    end
  end

  // A bubble clears valid and control but leaves the data fields as they were
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_RUN;
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_dst    <= '0;
      r_mem_to_reg <= '0;
      r_alu_src    <= '0;
      r_alu_op     <= '0;
      r_bus_a      <= '0;
      r_bus_b      <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_funct      <= '0;
      r_stall      <= '0;
    end else begin
      if (w_accept && w_halt) r_state <= ST_HALT;
      if (w_free) begin
        if (w_accept) begin
          r_valid      <= 1'b1;
          r_reg_write  <= w_ctrl[0];
          r_reg_dst    <= w_ctrl[2:1];
          r_mem_to_reg <= w_ctrl[4:3];
          r_mem_write  <= w_ctrl[5];
          r_alu_src    <= w_ctrl[7:6];
          r_alu_op     <= w_ctrl[10:8];
          r_bus_a      <= w_bus_a;
          r_bus_b      <= w_bus_b;
          r_imm        <= w_imm_ext;
          r_rs         <= w_rs;
          r_rt         <= w_rt;
          r_rd         <= w_rd;
          r_funct      <= w_funct;
        end else begin
          r_valid      <= 1'b0;
          r_reg_write  <= 1'b0;
          r_mem_write  <= 1'b0;
          r_reg_dst    <= '0;
          r_mem_to_reg <= '0;
          r_alu_src    <= '0;
          r_alu_op     <= '0;
        end
        if (w_load_use && i_valid && (r_stall != '1)) r_stall <= r_stall + 1'b1;
      end
    end
  end

  always_comb begin
    o_bus_debug = '0;
    for (int i = 0; i < REGISTERS_BANK_SIZE; i++) o_bus_debug[i*BUS_SIZE +: BUS_SIZE] = r_bank[i];
  end

  assign o_valid          = r_valid;
  assign o_reg_write      = r_reg_write;
  assign o_mem_write      = r_mem_write;
  assign o_reg_dst        = r_reg_dst;
  assign o_mem_to_reg     = r_mem_to_reg;
  assign o_alu_src        = r_alu_src;
  assign o_alu_op         = r_alu_op;
  assign o_bus_a          = r_bus_a;
  assign o_bus_b          = r_bus_b;
  assign o_imm_ext_signed = r_imm;
  assign o_rs             = r_rs;
  assign o_rt             = r_rt;
  assign o_rd             = r_rd;
  assign o_funct          = r_funct;
  assign o_halted         = (r_state == ST_HALT);
  assign o_stall_count    = r_stall;

endmodule
